ascon_serial_io: RTL

- Serial-to-parallel front end and parallel-to-serial back end for the Ascon decryption core, generalised to W bits per cycle per stream.
- Shifts in key, nonce, associated data and ciphertext MSB-first under a valid/ready handshake, then pulses the core start.
- Waits for the core to finish, then shifts plaintext and tag out MSB-first under a second valid/ready handshake.
- Sits between the chip pin interface and the Ascon core; replaces the fixed 1-bit serial load.

---
 rtl/ascon_serial_io.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ascon_serial_io.sv
// Serial load / unload front end for the Ascon decryption core, W bits per beat per stream.
// Optional expected-tag check enabled by defining ASCON_TAG_CHECK_EN.

module ascon_serial_io_sipo #(
  parameter int N  = 128,
  parameter int W  = 1,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] beatIdx,
  input  logic [W-1:0]  beat,
  output logic [N-1:0]  q
);
  localparam int IW = $clog2(N);

  // Lanes that fall below bit 0 of a short stream are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      for (int j = 0; j < W; j++) begin
        if (int'(beatIdx) * W + (W - 1 - j) < N)
          // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
          q[IW'(N - 1 - int'(beatIdx) * W - (W - 1 - j))] <= beat[j];
      end
    end
  end
endmodule

module ascon_serial_io #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 80,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] key_in,
  input  logic [W-1:0] nonce_in,
  input  logic [W-1:0] ad_in,
  input  logic [W-1:0] ct_in,
`ifdef ASCON_TAG_CHECK_EN
  input  logic [W-1:0] tag_exp_in,
  output logic         tag_ok,
`endif
  output logic [K-1:0] key_o,
  output logic [127:0] nonce_o,
  output logic [L-1:0] ad_o,
  output logic [Y-1:0] ct_o,
  output logic         core_start,
  input  logic         core_done,
  input  logic [Y-1:0] pt_i,
  input  logic [127:0] tag_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] pt_out,
  output logic [W-1:0] tag_out,
  output logic         busy,
  output logic         done
);
  localparam int KN        = (K > 128) ? K : 128;
  localparam int LY        = (L > Y) ? L : Y;
  localparam int IN_MAX    = (KN > LY) ? KN : LY;
  localparam int OUT_MAX   = (Y > 128) ? Y : 128;
  localparam int IN_BEATS  = IN_MAX / W;
  localparam int OUT_BEATS = OUT_MAX / W;
  localparam int BEATS_MAX = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
  localparam int CW        = $clog2(BEATS_MAX);

  if (!(W == 1 || W == 2 || W == 4 || W == 8) || (IN_MAX % W) != 0 || (OUT_MAX % W) != 0) begin : gBadParam
    $error("ascon_serial_io: W must be 1, 2, 4 or 8 and divide both stream maxima");
  end

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} stateT;

  stateT               state, stateNext;
  logic [CW-1:0]       beatCnt;
  logic [OUT_MAX-1:0]  ptSh, tagSh, ptAligned, tagAligned;
  logic                inAccept, outAccept, lastIn, lastOut;

  assign inAccept   = in_valid && in_ready;
  assign outAccept  = (state == UNLOAD) && out_ready;
  assign lastIn     = (beatCnt == CW'(IN_BEATS - 1));
  assign lastOut    = (beatCnt == CW'(OUT_BEATS - 1));
  // Streams are left-justified so beats past their length shift out as zeros.
  assign ptAligned  = OUT_MAX'(pt_i) << (OUT_MAX - Y);
  assign tagAligned = OUT_MAX'(tag_i) << (OUT_MAX - 128);
  assign pt_out     = ptSh[OUT_MAX-1 -: W];
  assign tag_out    = tagSh[OUT_MAX-1 -: W];

  ascon_serial_io_sipo #(.N(K),   .W(W), .CW(CW)) uKey   (.clk(clk), .rst(rst), .load(inAccept), .beatIdx(beatCnt), .beat(key_in),   .q(key_o));
  ascon_serial_io_sipo #(.N(128), .W(W), .CW(CW)) uNonce (.clk(clk), .rst(rst), .load(inAccept), .beatIdx(beatCnt), .beat(nonce_in), .q(nonce_o));
  ascon_serial_io_sipo #(.N(L),   .W(W), .CW(CW)) uAd    (.clk(clk), .rst(rst), .load(inAccept), .beatIdx(beatCnt), .beat(ad_in),    .q(ad_o));
  ascon_serial_io_sipo #(.N(Y),   .W(W), .CW(CW)) uCt    (.clk(clk), .rst(rst), .load(inAccept), .beatIdx(beatCnt), .beat(ct_in),    .q(ct_o));

`ifdef ASCON_TAG_CHECK_EN
  logic [127:0] tagExp;
  logic         tagMatch;

  ascon_serial_io_sipo #(.N(128), .W(W), .CW(CW)) uTagExp (.clk(clk), .rst(rst), .load(inAccept), .beatIdx(beatCnt), .beat(tag_exp_in), .q(tagExp));
  assign tagMatch = (tag_i == tagExp);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    stateNext  = state;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:   if (inAccept) stateNext = LOAD;
      LOAD:   if (inAccept && lastIn) stateNext = START;
      START: begin
        core_start = 1'b1;
        stateNext  = WAIT;
      end
      WAIT:   if (core_done) stateNext = UNLOAD;
      UNLOAD: begin
        out_valid = 1'b1;
        if (outAccept && lastOut) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beatCnt  <= '0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      ptSh     <= '0;
      tagSh    <= '0;
`ifdef ASCON_TAG_CHECK_EN
      tag_ok   <= 1'b0;
`endif
    end else begin
      in_ready <= (stateNext == IDLE) || (stateNext == LOAD);
      done     <= outAccept && lastOut;

      if (inAccept)       beatCnt <= lastIn  ? '0 : beatCnt + 1'b1;
      else if (outAccept) beatCnt <= lastOut ? '0 : beatCnt + 1'b1;

      if (state == WAIT && core_done) begin
`ifdef ASCON_TAG_CHECK_EN
        // A failed tag check withholds the whole plaintext.
        ptSh   <= tagMatch ? ptAligned : '0;
        tag_ok <= tagMatch;
`else
        ptSh   <= ptAligned;
`endif
        tagSh  <= tagAligned;
      end else if (outAccept) begin
        ptSh  <= ptSh << W;
        tagSh <= tagSh << W;
      end

`ifdef ASCON_TAG_CHECK_EN
      if (state == IDLE && inAccept) tag_ok <= 1'b0;
`endif
    end
  end
endmodule
